// File: rtl/montgomery_to_domain_if.sv
// Request/response bundle for the Montgomery-domain converter.
// The requester drives start and operands and the converter returns busy/result/valid/err.
interface montgomery_to_domain_if #(
  parameter int DATA_LENGTH = 64
);
  logic                   start_i;
  logic [DATA_LENGTH-1:0] x_i;
  logic [DATA_LENGTH-1:0] q_i;
  logic [DATA_LENGTH-1:0] q_bl_i;
  logic                   busy_o;
  logic [DATA_LENGTH-1:0] result_o;
  logic                   valid_o;
  logic                   err_o;

  modport master (
    output start_i, x_i, q_i, q_bl_i,
    input  busy_o, result_o, valid_o, err_o
  );

  modport slave (
    input  start_i, x_i, q_i, q_bl_i,
    output busy_o, result_o, valid_o, err_o
  );
endinterface

// File: rtl/montgomery_to_domain.sv
// Converts a canonical residue x into Montgomery form x*2^k mod q.
// One modular doubling per clock: acc starts at x and is doubled k times, reducing by q each step.
// Handshake: start accepted in IDLE, busy while working, one-cycle valid with result/err.
module montgomery_to_domain #(
  parameter int DATA_LENGTH = 64  // operand width shared with the multiplier datapath
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  montgomery_to_domain_if.slave    bus
);

  localparam int CNT_W = $clog2(DATA_LENGTH + 1);
  localparam logic [DATA_LENGTH-1:0] K_MAX = DATA_LENGTH'(DATA_LENGTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_LENGTH-1:0] r_acc;
  logic [DATA_LENGTH-1:0] r_q;
  logic [CNT_W-1:0]       r_cnt;
  logic                   r_err;
  logic [DATA_LENGTH-1:0] r_result;
  logic                   r_err_out;
  logic                   r_busy;
  logic                   r_valid;

  logic                   w_illegal;
  logic                   w_k_zero;
  logic                   w_load;
  logic                   w_step;
  logic                   w_finish;
  logic [DATA_LENGTH:0]   w_dbl;
  logic                   w_ge_q;
  logic [DATA_LENGTH-1:0] w_diff;
  logic [DATA_LENGTH-1:0] w_acc_next;

  // Request legality and the k==0 shortcut, evaluated on the live inputs at acceptance.
  assign w_illegal = (bus.q_i == '0) || (bus.x_i >= bus.q_i) || (bus.q_bl_i > K_MAX);
  assign w_k_zero  = (bus.q_bl_i == '0);

  // Modular doubling. The doubled value is kept one bit wider than q so a modulus
  // close to 2^DATA_LENGTH cannot overflow; since acc < q, t - q < q always fits
  // back into DATA_LENGTH bits, so the subtraction only needs the low bits.
  assign w_dbl      = {r_acc, 1'b0};
  assign w_ge_q     = (w_dbl >= {1'b0, r_q});
  assign w_diff     = w_dbl[DATA_LENGTH-1:0] - r_q;
  assign w_acc_next = w_ge_q ? w_diff : w_dbl[DATA_LENGTH-1:0];

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE, skipping RUN for k==0 or illegal requests.
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (bus.start_i) w_state_next = (w_illegal || w_k_zero) ? DONE : RUN;
      RUN:  if (r_cnt == CNT_W'(1)) w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: strobes that steer the datapath and output registers.
  always_comb begin
    w_load   = 1'b0;
    w_step   = 1'b0;
    w_finish = 1'b0;
    unique case (r_state)
      IDLE:    w_load   = bus.start_i;
      RUN:     w_step   = 1'b1;
      DONE:    w_finish = 1'b1;
      default: ;
    endcase
  end

  // Working registers: capture the request on acceptance, then double once per RUN cycle.
  // NOTE: every register here is small control/datapath state, so all of it is cleared by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_acc <= '0;
      r_q   <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (w_load) begin
      r_q   <= bus.q_i;
      r_cnt <= bus.q_bl_i[CNT_W-1:0];
      r_err <= w_illegal;
      r_acc <= w_illegal ? '0 : bus.x_i;
    end else if (w_step) begin
      r_acc <= w_acc_next;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Handshake outputs: busy after acceptance, valid pulse plus held result/err on leaving DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
      r_result  <= '0;
      r_err_out <= 1'b0;
    end else begin
      r_valid <= w_finish;
      if (w_load)        r_busy <= 1'b1;
      else if (w_finish) r_busy <= 1'b0;
      if (w_finish) begin
        r_result  <= r_acc;
        r_err_out <= r_err;
      end
    end
  end

  assign bus.busy_o   = r_busy;
  assign bus.valid_o  = r_valid;
  assign bus.result_o = r_result;
  assign bus.err_o    = r_err_out;

endmodule

// File: tb/tb_montgomery_to_domain.sv
// Directed and randomized checks of the Montgomery-domain converter.
module tb_montgomery_to_domain;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  montgomery_to_domain_if #(.DATA_LENGTH(64)) bus ();

  montgomery_to_domain #(.DATA_LENGTH(64)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: x*2^k mod q with plain wide arithmetic.
  function automatic logic [63:0] ref_model(input logic [63:0] x, input logic [63:0] q, input int k);
    logic [127:0] w;
    w = {64'd0, x} << k;
    return 64'(w % {64'd0, q});
  endfunction

  // Montgomery reduction y*2^-k mod q, bit-serial.
  function automatic logic [63:0] redc(input logic [63:0] y, input logic [63:0] q, input int k);
    logic [65:0] a;
    a = {2'b00, y};
    for (int i = 0; i < k; i++) begin
      if (a[0]) a = a + {2'b00, q};
      a = a >> 1;
    end
    if (a >= {2'b00, q}) a = a - {2'b00, q};
    return a[63:0];
  endfunction

  // One full handshake; lat counts clock edges from acceptance (inclusive) to valid, -1 on timeout.
  task automatic run_conv(input logic [63:0] x, input logic [63:0] q, input logic [63:0] k,
                          output logic [63:0] res, output logic err, output int lat,
                          output bit busy_ok);
    busy_ok = 1'b1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.x_i = x; bus.q_i = q; bus.q_bl_i = k;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.start_i = 1'b0;
    while (bus.valid_o !== 1'b1 && lat < 200) begin
      if (bus.busy_o !== 1'b1) busy_ok = 1'b0;
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    if (bus.valid_o !== 1'b1) lat = -1;
    else if (bus.busy_o !== 1'b0) busy_ok = 1'b0;
    res = bus.result_o;
    err = bus.err_o;
  endtask

  task automatic check_conv(input string name, input logic [63:0] x, input logic [63:0] q,
                            input logic [63:0] k, input logic [63:0] exp_res,
                            input logic exp_err, input int exp_lat);
    logic [63:0] res;
    logic        err;
    int          lat;
    bit          busy_ok;
    run_conv(x, q, k, res, err, lat, busy_ok);
    n_vec++;
    if (res !== exp_res) begin
      n_err++;
      $display("FAIL %s_result got %0h want %0h", name, res, exp_res);
    end
    n_vec++;
    if (err !== exp_err) begin
      n_err++;
      $display("FAIL %s_err got %0b want %0b", name, err, exp_err);
    end
    n_vec++;
    if (lat != exp_lat) begin
      n_err++;
      $display("FAIL %s_latency got %0d want %0d", name, lat, exp_lat);
    end
    n_vec++;
    if (!busy_ok) begin
      n_err++;
      $display("FAIL %s_busy got irregular busy_o want high until valid_o", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    bus.start_i = 1'b0; bus.x_i = '0; bus.q_i = '0; bus.q_bl_i = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bus.busy_o, bus.valid_o, bus.err_o, bus.result_o} !== 67'd0) begin
      n_err++;
      $display("FAIL reset_outputs got busy=%b valid=%b err=%b res=%0h want all zero",
               bus.busy_o, bus.valid_o, bus.err_o, bus.result_o);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    check_conv("t1", 64'd3, 64'd17, 64'd5, 64'd11, 1'b0, 7);
    repeat (3) @(negedge clk);
    n_vec++;
    if (bus.result_o !== 64'd11 || bus.valid_o !== 1'b0) begin
      n_err++;
      $display("FAIL t1_hold got res=%0d valid=%b want 11 0", bus.result_o, bus.valid_o);
    end
    check_conv("t2a", 64'd1, 64'd3329, 64'd16, 64'd2285, 1'b0, 18);
    check_conv("t2b", 64'd3328, 64'd3329, 64'd16, 64'd1044, 1'b0, 18);
  endtask

  task automatic test_k0_illegal();
    check_conv("k0", 64'd42, 64'd97, 64'd0, 64'd42, 1'b0, 2);
    check_conv("x_eq_q", 64'd97, 64'd97, 64'd0, 64'd0, 1'b1, 2);
    check_conv("q_zero", 64'd0, 64'd0, 64'd3, 64'd0, 1'b1, 2);
    check_conv("k_big", 64'd3, 64'd17, 64'd65, 64'd0, 1'b1, 2);
    check_conv("k_max", 64'd1, 64'd3, 64'd64, 64'd1, 1'b0, 66);
  endtask

  task automatic test_wide_modulus();
    check_conv("t4", 64'hFFFF_FFFF_FFFF_FFC4, 64'hFFFF_FFFF_FFFF_FFC5, 64'd64,
               64'hFFFF_FFFF_FFFF_FF8A, 1'b0, 66);
  endtask

  task automatic test_reset_mid_run();
    int nvalid = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.x_i = 64'd1; bus.q_i = 64'd3329; bus.q_bl_i = 64'd16;
    @(negedge clk);
    bus.start_i = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({bus.busy_o, bus.valid_o, bus.err_o, bus.result_o} !== 67'd0) begin
      n_err++;
      $display("FAIL midrun_reset got busy=%b valid=%b err=%b res=%0h want all zero",
               bus.busy_o, bus.valid_o, bus.err_o, bus.result_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.valid_o === 1'b1) nvalid++;
    end
    n_vec++;
    if (nvalid != 0) begin
      n_err++;
      $display("FAIL midrun_no_valid got %0d valid pulses want 0", nvalid);
    end
    check_conv("restart", 64'd3, 64'd17, 64'd5, 64'd11, 1'b0, 7);
  endtask

  task automatic test_start_during_run();
    int          nvalid = 0;
    logic [63:0] res = '0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.x_i = 64'd1; bus.q_i = 64'd3329; bus.q_bl_i = 64'd16;
    @(negedge clk);
    bus.start_i = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (i == 3) begin
        bus.start_i = 1'b1; bus.x_i = 64'd5; bus.q_i = 64'd17; bus.q_bl_i = 64'd2;
      end
      if (i == 4) bus.start_i = 1'b0;
      if (i == 8) begin
        bus.x_i = 64'd7; bus.q_i = 64'd97;
      end
      if (bus.valid_o === 1'b1) begin
        nvalid++;
        res = bus.result_o;
      end
      @(negedge clk);
    end
    n_vec++;
    if (nvalid != 1) begin
      n_err++;
      $display("FAIL ignore_start_count got %0d valid pulses want 1", nvalid);
    end
    n_vec++;
    if (res !== 64'd2285) begin
      n_err++;
      $display("FAIL ignore_start_result got %0d want 2285", res);
    end
  endtask

  task automatic test_back_to_back();
    int          pos[2];
    logic [63:0] res[2];
    int          nvalid = 0;
    @(negedge clk);
    bus.start_i = 1'b1; bus.x_i = 64'd3; bus.q_i = 64'd17; bus.q_bl_i = 64'd5;
    @(posedge clk);
    for (int i = 1; i <= 14; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 3) bus.x_i = 64'd5;
      if (bus.valid_o === 1'b1) begin
        if (nvalid < 2) begin
          pos[nvalid] = i;
          res[nvalid] = bus.result_o;
        end
        nvalid++;
      end
      if (i == 13) bus.start_i = 1'b0;
    end
    n_vec++;
    if (nvalid != 2) begin
      n_err++;
      $display("FAIL b2b_count got %0d want 2", nvalid);
    end else begin
      n_vec++;
      if (pos[0] != 6 || pos[1] != 13) begin
        n_err++;
        $display("FAIL b2b_timing got %0d,%0d want 6,13", pos[0], pos[1]);
      end
      n_vec++;
      if (res[0] !== 64'd11 || res[1] !== 64'd7) begin
        n_err++;
        $display("FAIL b2b_results got %0d,%0d want 11,7", res[0], res[1]);
      end
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_random();
    logic [63:0] x, q, res, exp_res;
    logic        err;
    int          k, lat, qw;
    bit          busy_ok;
    for (int n = 0; n < 300; n++) begin
      qw = $urandom_range(2, 64);
      q  = ({$urandom(), $urandom()} >> (64 - qw)) | 64'd1;
      x  = {$urandom(), $urandom()} % q;
      k  = $urandom_range(0, 64);
      exp_res = ref_model(x, q, k);
      run_conv(x, q, 64'(k), res, err, lat, busy_ok);
      n_vec++;
      if (res !== exp_res || err !== 1'b0 || lat != k + 2) begin
        n_err++;
        $display("FAIL rand_%0d got res=%0h err=%b lat=%0d want res=%0h err=0 lat=%0d (x=%0h q=%0h k=%0d)",
                 n, res, err, lat, exp_res, k + 2, x, q, k);
      end
      n_vec++;
      if (redc(res, q, k) !== x) begin
        n_err++;
        $display("FAIL rand_redc_%0d got %0h want %0h", n, redc(res, q, k), x);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_k0_illegal();
    test_wide_modulus();
    test_reset_mid_run();
    test_start_during_run();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
